req_encoder_hs: RTL and testbench

- Sequential N-to-log2(N) encoder; the encode-side counterpart to the team's 2-to-4 decoder.
- Captures one-cycle request pulses on a one-hot/multi-hot input into a pending register.
- Emits the index of one pending request per transfer over a valid/ready handshake, clearing each bit as it is served.
- Sits between event sources (interrupt lines, channel requests) and a consumer that handles one index at a time.

---
 rtl/req_encoder_hs.sv | 126 ++++++++++++
 tb/tb_req_encoder_hs.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/req_encoder_hs.sv
// Sequential N-to-log2(N) request encoder with a valid/ready output handshake.
// Define REQ_ENCODER_ROUND_ROBIN_EN for round-robin selection (default: fixed priority, bit 0 highest).
module req_encoder_hs #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] x,
  output logic [W-1:0] y,
  output logic         valid,
  input  logic         ready,
  output logic [N-1:0] pending,
  output logic         overflow
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  state_e       state_q, state_d;
  logic [W-1:0] y_q, y_d;
  logic [N-1:0] pending_q, pending_d;
  logic         overflow_q, overflow_d;

  logic         accept;
  logic [N-1:0] clr;
  logic [N-1:0] cand;
  logic [W-1:0] sel_idx;

  assign accept = (state_q == HOLD) && ready;

  // The offered index stays in pending until accepted, so a clear only ever
  // targets the bit currently on y.
  always_comb begin
    clr = '0;
    if (accept) clr = {{(N-1){1'b0}}, 1'b1} << y_q;
  end

  // A set from x is OR-ed in after the clear, so a same-cycle re-request re-arms the bit.
  assign cand      = (pending_q & ~clr) | x;
  assign pending_d = cand;

  // Duplicates include x bits matching the offered-but-unaccepted y.
  assign overflow_d = overflow_q | (|(x & pending_q & ~clr));

`ifdef REQ_ENCODER_ROUND_ROBIN_EN
  logic [W-1:0] ptr_q, ptr_d;
  logic [W-1:0] base;
  logic [W-1:0] pos;
  logic         found;

  // Search from the index just accepted, so back-to-back grants rotate without a bubble.
  assign base  = accept ? y_q : ptr_q;
  assign ptr_d = accept ? y_q : ptr_q;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    sel_idx = '0;
    pos     = '0;
    found   = 1'b0;
    for (int k = 1; k <= N; k++) begin
      pos = base + W'(k);  // W-bit add wraps modulo N
      if (!found && cand[pos]) begin
        sel_idx = pos;
        found   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= W'(N - 1);
    else        ptr_q <= ptr_d;
  end
`else
  always_comb begin
    sel_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (cand[i]) sel_idx = W'(i);
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    unique case (state_q)
      IDLE: begin
        if (|cand) begin
          y_d     = sel_idx;
          state_d = HOLD;
        end
      end
      HOLD: begin
        // Without ready, y is frozen; new requests only accumulate in pending.
        if (ready) begin
          if (|cand) y_d = sel_idx;
          else       state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      y_q        <= '0;
      pending_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
      state_q    <= state_d;
      y_q        <= y_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

  assign y        = y_q;
  assign valid    = (state_q == HOLD);
  assign pending  = pending_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_req_encoder_hs.sv
// Directed self-checking bench for req_encoder_hs (N=4, W=2); follows the
// REQ_ENCODER_ROUND_ROBIN_EN define for the arbitration expectations.
module tb_req_encoder_hs;

  logic       clk;
  logic       rst_n;
  logic [3:0] x;
  logic [1:0] y;
  logic       valid;
  logic       ready;
  logic [3:0] pending;
  logic       overflow;

  int total;
  int bad;

  req_encoder_hs #(.N(4), .W(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .x        (x),
    .y        (y),
    .valid    (valid),
    .ready    (ready),
    .pending  (pending),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle 1ns so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
  endtask

  logic [1:0] arb_exp [5];

  initial begin
    total = 0;
    bad   = 0;
`ifdef REQ_ENCODER_ROUND_ROBIN_EN
    arb_exp = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
`else
    arb_exp = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
`endif
    rst_n = 1'b0;
    x     = 4'b0000;
    ready = 1'b0;
    #12;
    check("rst_y",        32'(y),        32'd0);
    check("rst_valid",    32'(valid),    32'd0);
    check("rst_pending",  32'(pending),  32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    rst_n = 1'b1;
    tick();
    check("idle_valid", 32'(valid), 32'd0);

    // Single request, consumer always ready
    ready = 1'b1;
    x     = 4'b0100;
    tick();
    x = 4'b0000;
    check("single_valid",   32'(valid),   32'd1);
    check("single_y",       32'(y),       32'd2);
    check("single_pending", 32'(pending), 32'b0100);
    tick();
    check("single_done_valid",   32'(valid),    32'd0);
    check("single_done_pending", 32'(pending),  32'd0);
    check("single_y_holds",      32'(y),        32'd2);
    check("single_no_ovf",       32'(overflow), 32'd0);

    // Backpressure
    ready = 1'b0;
    x     = 4'b1010;
    tick();
    x = 4'b0000;
    check("bp_y0",       32'(y),       32'd1);
    check("bp_valid",    32'(valid),   32'd1);
    check("bp_pending",  32'(pending), 32'b1010);
    tick();
    check("bp_y1", 32'(y), 32'd1);
    tick();
    check("bp_y2", 32'(y), 32'd1);
    check("bp_pending2", 32'(pending), 32'b1010);
    ready = 1'b1;
    tick();
    check("bp_next_y",       32'(y),       32'd3);
    check("bp_next_valid",   32'(valid),   32'd1);
    check("bp_next_pending", 32'(pending), 32'b1000);
    tick();
    check("bp_done_valid",   32'(valid),   32'd0);
    check("bp_done_pending", 32'(pending), 32'd0);

    // Overflow by duplicate of the offered index
    ready = 1'b0;
    x     = 4'b0001;
    tick();
    check("ovf_first_y",   32'(y),        32'd0);
    check("ovf_first_ovf", 32'(overflow), 32'd0);
    tick();
    x = 4'b0000;
    check("ovf_set",     32'(overflow), 32'd1);
    check("ovf_pending", 32'(pending),  32'b0001);
    tick();
    check("ovf_sticky", 32'(overflow), 32'd1);
    check("ovf_offer_valid", 32'(valid), 32'd1);
    check("ovf_offer_y",     32'(y),     32'd0);
    ready = 1'b1;
    tick();
    check("ovf_one_grant_valid", 32'(valid),    32'd0);
    check("ovf_one_grant_pend",  32'(pending),  32'd0);
    check("ovf_sticky2",         32'(overflow), 32'd1);
    tick();
    check("ovf_stays_idle", 32'(valid), 32'd0);

    // Asynchronous reset mid-HOLD with y=2
    ready = 1'b0;
    x     = 4'b0100;
    tick();
    x = 4'b0000;
    check("hold_y2", 32'(y), 32'd2);
    #2 rst_n = 1'b0;
    #2;
    check("arst_y",        32'(y),        32'd0);
    check("arst_valid",    32'(valid),    32'd0);
    check("arst_pending",  32'(pending),  32'd0);
    check("arst_overflow", 32'(overflow), 32'd0);
    x = 4'b1111;
    tick();
    check("arst_held_pending", 32'(pending), 32'd0);
    check("arst_held_valid",   32'(valid),   32'd0);
    x = 4'b0000;
    #2 rst_n = 1'b1;

    // Re-arm: same-cycle accept and re-request of the offered bit
    ready = 1'b0;
    x     = 4'b0100;
    tick();
    check("rearm_setup_y", 32'(y), 32'd2);
    ready = 1'b1;
    x     = 4'b0100;
    tick();
    x     = 4'b0000;
    ready = 1'b0;
    check("rearm_no_ovf",  32'(overflow), 32'd0);
    check("rearm_pending", 32'(pending),  32'b0100);
    check("rearm_y",       32'(y),        32'd2);
    check("rearm_valid",   32'(valid),    32'd1);

    // Arbitration
    do_reset();
    ready = 1'b1;
    x     = 4'b1111;
    tick();
    x = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("arb_y%0d", i), 32'(y), 32'(arb_exp[i]));
      check($sformatf("arb_valid%0d", i), 32'(valid), 32'd1);
      x = (arb_exp[i] == 2'd0) ? 4'b0001 : 4'b0000;
      tick();
      x = 4'b0000;
    end
    check("arb_no_ovf", 32'(overflow), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
